// File: rtl/bram_bank_buffer_pkg.sv
// Shared types and constants for the multi-bank BRAM block buffer.
package bram_bank_buffer_pkg;

   localparam int DEFAULT_WIDTH      = 32;
   localparam int DEFAULT_NUM_BLOCKS = 128;
   localparam int DEFAULT_NUM_BANKS  = 2;

   localparam int WORD_AW = $clog2(DEFAULT_NUM_BLOCKS);
   localparam int BANK_AW = $clog2(DEFAULT_NUM_BANKS);

   // One BRAM register stage plus one output register.
   localparam int READ_LATENCY = 2;

   typedef struct packed {
      logic valid;
      logic last;
   } rd_pipe_t;

endpackage

// File: rtl/bram_bank_buffer_bank_tracker.sv
// Bank bookkeeping: write/read pointers, completed-bank count and handshake readiness.
module bram_bank_buffer_bank_tracker #(
   parameter int NUM_BLOCKS = 128,
   parameter int NUM_BANKS  = 2
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     write_valid_in,
   input  logic                                     read_next_in,
   input  logic                                     replay_in,
   output logic                                     write_ready_out,
   output logic                                     read_ready_out,
   output logic                                     wr_accept_out,
   output logic                                     rd_accept_out,
   output logic                                     rd_last_out,
   output logic [$clog2(NUM_BANKS*NUM_BLOCKS)-1:0]  wr_addr_out,
   output logic [$clog2(NUM_BANKS*NUM_BLOCKS)-1:0]  rd_addr_out,
   output logic [$clog2(NUM_BANKS):0]               full_count_out
);

   localparam int WORD_BITS = $clog2(NUM_BLOCKS);
   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int CNT_BITS  = BANK_BITS + 1;
   localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(NUM_BLOCKS - 1);
   localparam logic [CNT_BITS-1:0]  BANK_CNT  = CNT_BITS'(NUM_BANKS);

   logic [WORD_BITS-1:0] wr_word_q, wr_word_d, rd_word_q, rd_word_d;
   logic [BANK_BITS-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [CNT_BITS-1:0]  full_cnt_q, full_cnt_d;
   logic                 commit, release_bank;

   assign write_ready_out = (full_cnt_q < BANK_CNT);
   assign read_ready_out  = (full_cnt_q != '0);
   assign wr_accept_out   = write_valid_in & write_ready_out;
   assign rd_accept_out   = read_next_in & read_ready_out;
   assign commit          = wr_accept_out & (wr_word_q == LAST_WORD);
   assign rd_last_out     = rd_accept_out & (rd_word_q == LAST_WORD);
   assign release_bank    = rd_last_out & ~replay_in;
   assign wr_addr_out     = {wr_bank_q, wr_word_q};
   assign rd_addr_out     = {rd_bank_q, rd_word_q};
   assign full_count_out  = full_cnt_q;

   // Word pointers wrap naturally at NUM_BLOCKS; bank pointers wrap at NUM_BANKS.
   always_comb begin
      wr_word_d  = wr_word_q;
      wr_bank_d  = wr_bank_q;
      rd_word_d  = rd_word_q;
      rd_bank_d  = rd_bank_q;
      full_cnt_d = full_cnt_q;
      if (wr_accept_out) begin
         wr_word_d = wr_word_q + WORD_BITS'(1);
      end
      if (commit) begin
         wr_bank_d = wr_bank_q + BANK_BITS'(1);
      end
      if (rd_accept_out) begin
         rd_word_d = rd_word_q + WORD_BITS'(1);
      end
      if (release_bank) begin
         rd_bank_d = rd_bank_q + BANK_BITS'(1);
      end
      case ({commit, release_bank})
         2'b10:   full_cnt_d = full_cnt_q + CNT_BITS'(1);
         2'b01:   full_cnt_d = full_cnt_q - CNT_BITS'(1);
         default: full_cnt_d = full_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_word_q  <= '0;
         wr_bank_q  <= '0;
         rd_word_q  <= '0;
         rd_bank_q  <= '0;
         full_cnt_q <= '0;
      end else begin
         wr_word_q  <= wr_word_d;
         wr_bank_q  <= wr_bank_d;
         rd_word_q  <= rd_word_d;
         rd_bank_q  <= rd_bank_d;
         full_cnt_q <= full_cnt_d;
      end
   end

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Dual-port read-first block RAM: port A is a read port, port B a read-first write port.
module xilinx_true_dual_port_read_first_2_clock_ram #(
   parameter int RAM_WIDTH = 32,
   parameter int RAM_DEPTH = 256
) (
   input  logic                         clka,
   input  logic                         ena,
   input  logic [$clog2(RAM_DEPTH)-1:0] addra,
   output logic [RAM_WIDTH-1:0]         douta,
   input  logic                         clkb,
   input  logic                         enb,
   input  logic                         web,
   input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
   input  logic [RAM_WIDTH-1:0]         dinb,
   output logic [RAM_WIDTH-1:0]         doutb
);

   logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];

   always_ff @(posedge clka) begin
      if (ena) begin
         douta <= ram[addra];
      end
   end

   // Only port B writes, so the array has a single driving process.
   always_ff @(posedge clkb) begin
      if (enb) begin
         if (web) begin
            ram[addrb] <= dinb;
         end
         doutb <= ram[addrb];
      end
   end

endmodule

// File: rtl/bram_bank_buffer.sv
// Multi-bank BRAM block buffer: producer fills banks in order, consumer drains completed banks.
// Optional bank replay on the last read is enabled with `define BRAM_BANK_BUFFER_REPLAY_EN.
module bram_bank_buffer
   import bram_bank_buffer_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int NUM_BLOCKS = DEFAULT_NUM_BLOCKS,
   parameter int NUM_BANKS  = DEFAULT_NUM_BANKS
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       write_valid_in,
   input  logic [WIDTH-1:0]           write_block_in,
   output logic                       write_ready_out,
   output logic                       write_overflow_out,
   input  logic                       read_next_in,
`ifdef BRAM_BANK_BUFFER_REPLAY_EN
   input  logic                       replay_in,
`endif
   output logic                       read_ready_out,
   output logic [WIDTH-1:0]           read_block_out,
   output logic                       read_valid_out,
   output logic                       read_last_out,
   output logic [$clog2(NUM_BANKS):0] banks_full_out
);

   localparam int ADDR_BITS = $clog2(NUM_BANKS * NUM_BLOCKS);

   logic [1:0]           rst_sync_q, rst_sync_d;
   logic                 rst_n;
   logic                 replay;
   logic                 wr_accept, rd_accept, rd_last;
   logic [ADDR_BITS-1:0] wr_addr, rd_addr;
   logic [WIDTH-1:0]     bram_douta, bram_b_unused;
   rd_pipe_t             pipe_q [READ_LATENCY];
   rd_pipe_t             pipe_d [READ_LATENCY];
   logic [WIDTH-1:0]     rd_data_q, rd_data_d;
   logic                 overflow_q, overflow_d;

`ifdef BRAM_BANK_BUFFER_REPLAY_EN
   assign replay = replay_in;
`else
   assign replay = 1'b0;
`endif

   // Reset asserts immediately but is released only on a clock edge.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_n = rst_sync_q[1];

   bram_bank_buffer_bank_tracker #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .NUM_BANKS  (NUM_BANKS)
   ) u_tracker (
      .clk             (clk_in),
      .rst_n           (rst_n),
      .write_valid_in  (write_valid_in),
      .read_next_in    (read_next_in),
      .replay_in       (replay),
      .write_ready_out (write_ready_out),
      .read_ready_out  (read_ready_out),
      .wr_accept_out   (wr_accept),
      .rd_accept_out   (rd_accept),
      .rd_last_out     (rd_last),
      .wr_addr_out     (wr_addr),
      .rd_addr_out     (rd_addr),
      .full_count_out  (banks_full_out)
   );

   xilinx_true_dual_port_read_first_2_clock_ram #(
      .RAM_WIDTH (WIDTH),
      .RAM_DEPTH (NUM_BANKS * NUM_BLOCKS)
   ) u_bram (
      .clka  (clk_in),
      .ena   (rd_accept),
      .addra (rd_addr),
      .douta (bram_douta),
      .clkb  (clk_in),
      .enb   (wr_accept),
      .web   (wr_accept),
      .addrb (wr_addr),
      .dinb  (write_block_in),
      .doutb (bram_b_unused)
   );

   // The data register captures zero whenever no word is leaving the BRAM stage.
   always_comb begin
      pipe_d[0].valid = rd_accept;
      pipe_d[0].last  = rd_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      rd_data_d  = pipe_q[READ_LATENCY-2].valid ? bram_douta : '0;
      overflow_d = overflow_q | (write_valid_in & ~write_ready_out);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
         rd_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
         rd_data_q  <= rd_data_d;
         overflow_q <= overflow_d;
      end
   end

   assign read_valid_out     = pipe_q[READ_LATENCY-1].valid;
   assign read_last_out      = pipe_q[READ_LATENCY-1].last;
   assign read_block_out     = rd_data_q;
   assign write_overflow_out = overflow_q;

endmodule
